operand_loader: RTL

OPERAND_LOADER -- requirements
Module: OPERAND_LOADER

---
 rtl/operand_loader_pkg.sv | 13 +
 rtl/operand_loader_debounce.sv | 54 +++++
 rtl/operand_loader.sv | 106 ++++++++++
 3 files changed

// File: rtl/operand_loader_pkg.sv
// Shared types and constants for the operand loader and its bench.
// State encodings are fixed so the bench can reason about them directly.
package operand_loader_pkg;

  localparam int BYTES_PER_OPERAND = 4;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/operand_loader_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter, rise detector.
// Emits one registered pulse per accepted 0->1 level change.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1
                    : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    pulse_d = 1'b0;
    // Any cycle that agrees with the accepted level restarts the count.
    if (s2_q != level_q) begin
      if (cnt_q == LAST) begin
        level_d = s2_q;
        pulse_d = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      s1_q    <= btn_i;
      s2_q    <= s1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/operand_loader.sv
// Loads two 32-bit operands byte-by-byte (LSB first) from switches,
// one byte per debounced button press.
module operand_loader
  import operand_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic        OPERAND_LOADER_clk_xi,
  input  logic        OPERAND_LOADER_rst_xi,
  input  logic [7:0]  OPERAND_LOADER_data_SW_xi,
  input  logic        OPERAND_LOADER_BTN_xi,
  input  logic        OPERAND_LOADER_clear_xi,
  output logic [31:0] OPERAND_LOADER_A_xo,
  output logic [31:0] OPERAND_LOADER_B_xo,
  output logic        OPERAND_LOADER_valid_xo,
  output logic [2:0]  OPERAND_LOADER_idx_xo,
  output logic [7:0]  OPERAND_LOADER_LED_xo
);

  logic        clk, rst, load;
  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        valid_q, valid_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  led_q, led_d;

  assign clk = OPERAND_LOADER_clk_xi;
  assign rst = OPERAND_LOADER_rst_xi;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk_i  (clk),
    .rst_i  (rst),
    .btn_i  (OPERAND_LOADER_BTN_xi),
    .pulse_o(load)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    valid_d = valid_q;
    led_d   = led_q;
    // Clear wins over a coincident load pulse.
    if (OPERAND_LOADER_clear_xi) begin
      state_d = LOAD_A;
      cnt_d   = '0;
      a_d     = '0;
      b_d     = '0;
      valid_d = 1'b0;
      led_d   = '0;
    end else if (load) begin
      unique case (state_q)
        LOAD_A: begin
          a_d[{cnt_q, 3'b000} +: 8] = OPERAND_LOADER_data_SW_xi;
          led_d = OPERAND_LOADER_data_SW_xi;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'(BYTES_PER_OPERAND - 1))
            state_d = LOAD_B;
        end
        LOAD_B: begin
          b_d[{cnt_q, 3'b000} +: 8] = OPERAND_LOADER_data_SW_xi;
          led_d = OPERAND_LOADER_data_SW_xi;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'(BYTES_PER_OPERAND - 1)) begin
            state_d = DONE;
            valid_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
    idx_d = (state_d == DONE) ? 3'd7
          : {state_d == LOAD_B, cnt_d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD_A;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      led_q   <= led_d;
    end
  end

  assign OPERAND_LOADER_A_xo     = a_q;
  assign OPERAND_LOADER_B_xo     = b_q;
  assign OPERAND_LOADER_valid_xo = valid_q;
  assign OPERAND_LOADER_idx_xo   = idx_q;
  assign OPERAND_LOADER_LED_xo   = led_q;

endmodule
